// File: rtl/if_id_stage_pkg.sv
// Shared types and constants for the fetch-to-decode pipeline register.
// Holds exception codes, the eret word, reset PC and the D-entry state encoding.
package if_id_stage_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  exc_t;

    localparam exc_t  EXC_NONE  = 5'd0;
    localparam exc_t  EXC_ADEL  = 5'd4;
    localparam word_t ERET_WORD = 32'h42000018;
    localparam word_t RESET_PC  = 32'h00003000;
    localparam word_t LINK_OFS  = 32'd8;

    typedef enum logic [1:0] {
        ST_BUBBLE = 2'd0,
        ST_RUN    = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

    // Payload of the D-stage entry (validity is tracked by the FSM).
    typedef struct packed {
        word_t instr;
        word_t pc;
        exc_t  exccode;
        logic  bd;
    } de_entry_t;

    // Empty slot; the PC still follows fetch so later stages see a
    // sensible address for the bubble.
    function automatic de_entry_t bubble_entry(input word_t pc);
        de_entry_t e;
        e.instr   = '0;
        e.pc      = pc;
        e.exccode = EXC_NONE;
        e.bd      = 1'b0;
        return e;
    endfunction

    // A faulting fetch carries no instruction word, only the fault code.
    function automatic de_entry_t load_entry(
        input word_t instr,
        input word_t pc,
        input logic  adel,
        input logic  bd
    );
        de_entry_t e;
        e.instr   = adel ? '0 : instr;
        e.pc      = pc;
        e.exccode = adel ? EXC_ADEL : EXC_NONE;
        e.bd      = bd;
        return e;
    endfunction

endpackage

// File: rtl/if_id_stage_if.sv
// Bundle between the fetch side and the if_id_stage register.
// master: fetch/control driver; slave: the pipeline register itself.
interface if_id_stage_if;
    import if_id_stage_pkg::*;

    logic  stall;
    logic  flush;
    word_t instr_f;
    word_t pc_f;
    logic  adel_f;
    logic  bd_f;

    word_t instr_d;
    word_t pc_d;
    word_t pc8_d;
    exc_t  exccode_d;
    logic  bd_d;
    logic  valid_d;
    word_t fetch_cnt;

    modport master (
        output stall, flush, instr_f, pc_f, adel_f, bd_f,
        input  instr_d, pc_d, pc8_d, exccode_d, bd_d,
        input  valid_d, fetch_cnt
    );

    modport slave (
        input  stall, flush, instr_f, pc_f, adel_f, bd_f,
        output instr_d, pc_d, pc8_d, exccode_d, bd_d,
        output valid_d, fetch_cnt
    );
endinterface

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with BUBBLE/RUN/HOLD control, eret-kill and fetch count.
// Ports: clk, reset (sync, active-high), bus (if_id_stage_if.slave: F inputs, D outputs).
module if_id_stage
    import if_id_stage_pkg::*;
#(
    parameter word_t P_CNT_RESET = 32'd0
) (
    input  logic           clk,
    input  logic           reset,
    if_id_stage_if.slave   bus
);

    state_e    r_state;
    de_entry_t r_entry;
    logic      r_valid;
    word_t     r_cnt;

    state_e    w_nxt_state;
    de_entry_t w_nxt_entry;
    word_t     w_nxt_cnt;

    logic      w_is_eret;
    logic      w_do_flush;
    logic      w_do_hold;
    logic      w_do_kill;
    logic      w_do_load;

    // eret has no delay slot, so the word behind it must never issue.
    assign w_is_eret  = r_valid && (r_entry.instr == ERET_WORD);

    // Mutually exclusive action selects, in priority order.
    assign w_do_flush = bus.flush;
    assign w_do_hold  = !bus.flush && bus.stall;
    assign w_do_kill  = !bus.flush && !bus.stall && w_is_eret;
    assign w_do_load  = !bus.flush && !bus.stall && !w_is_eret;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_entry = r_entry;
        w_nxt_cnt   = r_cnt;
        unique case (1'b1)
            w_do_flush: begin
                w_nxt_state = ST_BUBBLE;
                w_nxt_entry = bubble_entry(bus.pc_f);
            end
            w_do_hold: begin
                w_nxt_state = r_valid ? ST_HOLD : ST_BUBBLE;
            end
            w_do_kill: begin
                w_nxt_state = ST_BUBBLE;
                w_nxt_entry = bubble_entry(bus.pc_f);
            end
            w_do_load: begin
                w_nxt_state = ST_RUN;
                w_nxt_entry = load_entry(bus.instr_f, bus.pc_f,
                                         bus.adel_f, bus.bd_f);
                w_nxt_cnt   = r_cnt + 32'd1;
            end
            default: begin
                w_nxt_state = r_state;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_BUBBLE;
            r_entry <= bubble_entry(RESET_PC);
            r_valid <= 1'b0;
            r_cnt   <= P_CNT_RESET;
        end else begin
            r_state <= w_nxt_state;
            r_entry <= w_nxt_entry;
            r_valid <= (w_nxt_state != ST_BUBBLE);
            r_cnt   <= w_nxt_cnt;
        end
    end

    assign bus.instr_d   = r_entry.instr;
    assign bus.pc_d      = r_entry.pc;
    assign bus.pc8_d     = r_entry.pc + LINK_OFS;
    assign bus.exccode_d = r_entry.exccode;
    assign bus.bd_d      = r_entry.bd;
    assign bus.valid_d   = r_valid;
    assign bus.fetch_cnt = r_cnt;

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed scenarios plus random traffic
// compared every cycle against a behavioural model of the D entry.
module tb_if_id_stage;
    import if_id_stage_pkg::*;

    localparam word_t CNT2_INIT = 32'hFFFF_FFFD;

    logic clk;
    logic reset;

    if_id_stage_if bus ();
    if_id_stage_if bus2 ();

    if_id_stage u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    if_id_stage #(.P_CNT_RESET(CNT2_INIT)) u_dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.slave)
    );

    assign bus2.stall   = bus.stall;
    assign bus2.flush   = bus.flush;
    assign bus2.instr_f = bus.instr_f;
    assign bus2.pc_f    = bus.pc_f;
    assign bus2.adel_f  = bus.adel_f;
    assign bus2.bd_f    = bus.bd_f;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;
    bit chk_en;

    // Model of what D must hold after the most recent edge.
    word_t m_instr;
    word_t m_pc;
    exc_t  m_exc;
    logic  m_bd;
    logic  m_valid;
    word_t m_cnt;
    word_t m_cnt2;

    task automatic cmp(input string n, input word_t act, input word_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h @%0t", n, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("instr_d",    bus.instr_d,           m_instr);
            cmp("pc_d",       bus.pc_d,              m_pc);
            cmp("pc8_d",      bus.pc8_d,             m_pc + 32'd8);
            cmp("exccode_d",  {27'd0, bus.exccode_d}, {27'd0, m_exc});
            cmp("bd_d",       {31'd0, bus.bd_d},      {31'd0, m_bd});
            cmp("valid_d",    {31'd0, bus.valid_d},   {31'd0, m_valid});
            cmp("fetch_cnt",  bus.fetch_cnt,         m_cnt);
            cmp("instr_d2",   bus2.instr_d,          m_instr);
            cmp("pc8_d2",     bus2.pc8_d,            m_pc + 32'd8);
            cmp("misc2",
                {bus2.pc_d, 25'd0, bus2.exccode_d, bus2.bd_d, bus2.valid_d},
                {m_pc, 25'd0, m_exc, m_bd, m_valid});
            cmp("fetch_cnt2", bus2.fetch_cnt,        m_cnt2);
        end
    end

    // Rules for one clock edge, applied to the inputs currently driven.
    task automatic model_update();
        if (reset) begin
            m_instr = 32'd0;
            m_pc    = 32'h0000_3000;
            m_exc   = 5'd0;
            m_bd    = 1'b0;
            m_valid = 1'b0;
            m_cnt   = 32'd0;
            m_cnt2  = CNT2_INIT;
        end else if (bus.flush ||
                     (!bus.stall && m_valid && m_instr == 32'h4200_0018)) begin
            m_instr = 32'd0;
            m_pc    = bus.pc_f;
            m_exc   = 5'd0;
            m_bd    = 1'b0;
            m_valid = 1'b0;
        end else if (!bus.stall) begin
            m_instr = bus.adel_f ? 32'd0 : bus.instr_f;
            m_pc    = bus.pc_f;
            m_exc   = bus.adel_f ? 5'd4 : 5'd0;
            m_bd    = bus.bd_f;
            m_valid = 1'b1;
            m_cnt   = m_cnt + 32'd1;
            m_cnt2  = m_cnt2 + 32'd1;
        end
    endtask

    task automatic step(input logic rst, input logic st, input logic fl,
                        input word_t ins, input word_t pc,
                        input logic ad, input logic bd);
        reset       = rst;
        bus.stall   = st;
        bus.flush   = fl;
        bus.instr_f = ins;
        bus.pc_f    = pc;
        bus.adel_f  = ad;
        bus.bd_f    = bd;
        @(posedge clk);
        #1;
        model_update();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        chk_en   = 1'b0;
        reset    = 1'b1;
        bus.stall = 1'b0; bus.flush = 1'b0; bus.instr_f = '0;
        bus.pc_f = '0; bus.adel_f = 1'b0; bus.bd_f = 1'b0;

        step(1, 0, 0, 32'h0, 32'h0, 0, 0);
        chk_en = 1'b1;
        cmp("rst_valid", {31'd0, bus.valid_d}, 32'd0);
        cmp("rst_pc8",   bus.pc8_d,            32'h0000_3008);
        cmp("rst_cnt",   bus.fetch_cnt,        32'd0);
        cmp("rst_cnt2",  bus2.fetch_cnt,       32'hFFFF_FFFD);

        step(0, 0, 0, 32'h2401_0005, 32'h3000, 0, 0);
        cmp("ld_instr", bus.instr_d, 32'h2401_0005);
        cmp("ld_pc8",   bus.pc8_d,   32'h0000_3008);
        cmp("ld_valid", {31'd0, bus.valid_d}, 32'd1);
        cmp("ld_cnt",   bus.fetch_cnt, 32'd1);

        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 32'hA000_0000 + i, 32'h3100 + 4 * i, 0, 1);
            cmp("stall_instr", bus.instr_d, 32'h2401_0005);
            cmp("stall_cnt",   bus.fetch_cnt, 32'd1);
        end
        step(0, 0, 0, 32'h3402_0007, 32'h3004, 0, 0);
        cmp("rel_instr", bus.instr_d, 32'h3402_0007);
        cmp("rel_cnt",   bus.fetch_cnt, 32'd2);

        step(0, 0, 0, 32'h4200_0018, 32'h3008, 0, 0);
        cmp("eret_in", bus.instr_d, 32'h4200_0018);
        step(0, 0, 0, 32'h1111_1111, 32'h300C, 0, 0);
        cmp("kill_valid", {31'd0, bus.valid_d}, 32'd0);
        cmp("kill_instr", bus.instr_d, 32'd0);
        cmp("kill_pc",    bus.pc_d,    32'h0000_300C);
        cmp("kill_cnt",   bus.fetch_cnt, 32'd3);

        step(0, 0, 0, 32'hDEAD_BEEF, 32'h3002, 1, 0);
        cmp("adel_instr", bus.instr_d, 32'd0);
        cmp("adel_exc",   {27'd0, bus.exccode_d}, 32'd4);
        cmp("adel_pc",    bus.pc_d, 32'h0000_3002);
        cmp("adel_valid", {31'd0, bus.valid_d}, 32'd1);

        step(0, 1, 1, 32'h5555_5555, 32'h4180, 0, 0);
        cmp("fs_valid", {31'd0, bus.valid_d}, 32'd0);
        cmp("fs_pc",    bus.pc_d, 32'h0000_4180);
        step(0, 0, 0, 32'h8C01_0000, 32'h3010, 0, 1);
        cmp("bd_d", {31'd0, bus.bd_d}, 32'd1);

        step(0, 0, 1, 32'h1234_5678, 32'h3015, 1, 0);
        cmp("fa_valid", {31'd0, bus.valid_d}, 32'd0);
        cmp("fa_exc",   {27'd0, bus.exccode_d}, 32'd0);
        step(0, 1, 0, 32'h1234_5678, 32'h3018, 0, 0);
        cmp("bub_hold", {31'd0, bus.valid_d}, 32'd0);

        step(1, 1, 1, 32'h1234_5678, 32'h4000, 1, 1);
        cmp("rst_mid_pc",  bus.pc_d, 32'h0000_3000);
        cmp("rst_mid_cnt", bus.fetch_cnt, 32'd0);

        step(0, 0, 0, 32'h0000_0001, 32'hFFFF_FFFC, 0, 0);
        cmp("pc8_wrap", bus.pc8_d, 32'h0000_0004);
        cmp("wrap_a", bus2.fetch_cnt, 32'hFFFF_FFFE);
        step(0, 0, 0, 32'h0000_0002, 32'h3000, 0, 0);
        cmp("wrap_b", bus2.fetch_cnt, 32'hFFFF_FFFF);
        step(0, 0, 0, 32'h0000_0003, 32'h3004, 0, 0);
        cmp("wrap_c", bus2.fetch_cnt, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            logic  r_rst;
            logic  r_st;
            logic  r_fl;
            word_t r_ins;
            word_t r_pc;
            r_rst = ($urandom_range(99) == 0);
            r_st  = ($urandom_range(3) == 0);
            r_fl  = ($urandom_range(9) == 0);
            r_ins = ($urandom_range(3) == 0) ? 32'h4200_0018 : $urandom;
            case ($urandom_range(3))
                0:       r_pc = 32'hFFFF_FFF8 + {$urandom_range(1), 2'b00};
                1:       r_pc = $urandom;
                default: r_pc = 32'h3000 + {$urandom_range(2047), 2'b00};
            endcase
            step(r_rst, r_st, r_fl, r_ins, r_pc,
                 ($urandom_range(6) == 0), $urandom_range(1) == 1);
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 The block SHALL be clocked by clk and reset by reset, synchronous, active-high.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 stall  input  1  hazard stall from D stage: hold the current D contents.
REQ-005 flush  input  1  exception entry or eret committed in M: kill the fetched entry.
REQ-006 instr_f  input  32  fetched instruction word.
REQ-007 pc_f  input  32  fetch PC.
REQ-008 adel_f  input  1  fetch address error (misaligned or outside 0x3000-0x4ffc).
REQ-009 bd_f  input  1  the instruction now in D is a branch/jump, so instr_f is its delay slot.
REQ-010 instr_d  output  32  D-stage instruction.
REQ-011 pc_d  output  32  D-stage PC.
REQ-012 pc8_d  output  32  pc_d+8, used as link value.
REQ-013 exccode_d  output  5  pending exception code carried to later stages.
REQ-014 bd_d  output  1  D-stage instruction is a delay slot.
REQ-015 valid_d  output  1  D-stage entry is a real instruction, not a bubble.
REQ-016 fetch_cnt  output  32  count of valid instructions accepted into D.

Function
REQ-017 The FSM SHALL have three states: BUBBLE (valid_d=0), RUN (valid, advancing) and HOLD (valid, stalled).
- Priority order each cycle: reset > flush > stall > eret-kill > normal load.

REQ-018 On flush, the block SHALL enter BUBBLE next cycle regardless of stall.
- Bubble contents: instr_d=0, exccode_d=0, bd_d=0, pc_d=pc_f.

REQ-019 On stall with no flush, the block SHALL hold every output unchanged.
- State goes to HOLD if valid, otherwise stays BUBBLE.
- fetch_cnt does not increment.

REQ-020 Eret-kill: when instr_d==32'h42000018, valid_d=1, and there is no stall and no flush, the next entry SHALL be a bubble with pc_d=pc_f.
- eret has no delay slot.

REQ-021 Normal load SHALL latch instr_f, pc_f and bd_f, set valid_d=1, go to RUN, and increment fetch_cnt by 1.
- fetch_cnt wraps modulo 2^32.

REQ-022 When adel_f=1 on a load, the block SHALL latch instr_d=0 and exccode_d=5'd4.
- pc_d and bd_d are latched as normal; valid_d=1.

REQ-023 When adel_f=0 on a load, the block SHALL latch exccode_d=0.

REQ-024 pc8_d SHALL be combinational pc_d+32'd8, truncated to 32 bits with wrap.

REQ-025 From HOLD, deasserting stall SHALL perform a normal load (or eret-kill) in that same cycle's edge.

REQ-026 A simultaneous flush and adel_f SHALL produce a bubble: the flushed fault is discarded.

Reset
REQ-027 On reset the block SHALL set:
- state=BUBBLE;
- instr_d=0, pc_d=32'h00003000 (so pc8_d=32'h00003008);
- exccode_d=0, bd_d=0, valid_d=0, fetch_cnt=0.

REQ-028 Reset asserted mid-stall or mid-flush SHALL override all other inputs in that cycle.

Structure
REQ-029 The shared package SHALL hold:
- EXC_ADEL=5'd4 and EXC_NONE=5'd0;
- ERET_WORD=32'h42000018;
- RESET_PC=32'h00003000;
- the state encoding constants.

REQ-030 No sub-module is required.
- Next-entry selection SHALL be one combinational block feeding one registered block.

Verification
REQ-031 Reset, then load instr_f=0x24010005, pc_f=0x3000 -> next cycle instr_d=0x24010005, pc8_d=0x3008, valid_d=1, fetch_cnt=1.

REQ-032 Stall held 3 cycles while instr_f changes -> outputs constant, fetch_cnt unchanged; release -> new word loaded.

REQ-033 instr_d=0x42000018 in D, no stall -> next cycle valid_d=0, instr_d=0, pc_d=pc_f.

REQ-034 adel_f=1 with pc_f=0x3002 -> instr_d=0, exccode_d=4, pc_d=0x3002, valid_d=1.

REQ-035 flush=1 and stall=1 together -> BUBBLE; bd_f=1 on the following load -> bd_d=1.

REQ-036 fetch_cnt preset near 0xFFFFFFFF by a run of loads -> increments to 0xFFFFFFFF, then wraps to 0.
